calc_entry_ctrl: RTL and testbench

//  Keypad/operator entry sequencer for the calculator. Turns level switch inputs into single key events
//  (12-key pad swp, 8 operator switches swd) and assembles two BCD operands and an opcode.

---
 rtl/calc_entry_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// calc_entry_ctrl
//
// Keypad / operator entry sequencer for the calculator. Level switch inputs
// are turned into single key events, two BCD operands and an opcode are
// assembled, the ALU is driven through a start/done handshake and the LCD
// driver is told what to show and when to redraw.
//
// Ports
//   clk        in   system clock, everything on the rising edge
//   rst        in   synchronous active-high reset
//   swp[11:0]  in   keypad levels: [11..3]=digits 1..9, [2]='*' clear,
//                   [1]='0', [0]='#' backspace
//   swd[7:0]   in   operator levels: [7]=+ [6]=- [5]=x [4]=/ [3:1] unused,
//                   [0]='='
//   op_a       out  operand A, BCD, least significant digit in [3:0]
//   op_b       out  operand B, BCD
//   op_code    out  0=add 1=sub 2=mul 3=div
//   alu_start  out  one-cycle start pulse to the ALU
//   alu_done   in   ALU result valid pulse
//   alu_err    in   qualified by alu_done; overflow / divide-by-zero
//   disp_sel   out  0=A 1=B 2=ALU result 3="Err"
//   disp_upd   out  one-cycle pulse: LCD redraws according to disp_sel
//   busy       out  high while the ALU operation is in flight
// ---------------------------------------------------------------------------
module calc_entry_ctrl #(
  parameter int MAX_DIGITS  = 4,
  parameter int ALU_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             swp,
  input  logic [7:0]              swd,
  output logic [4*MAX_DIGITS-1:0] op_a,
  output logic [4*MAX_DIGITS-1:0] op_b,
  output logic [1:0]              op_code,
  output logic                    alu_start,
  input  logic                    alu_done,
  input  logic                    alu_err,
  output logic [1:0]              disp_sel,
  output logic                    disp_upd,
  output logic                    busy
);

  localparam int OPW   = 4 * MAX_DIGITS;
  localparam int CW    = $clog2(MAX_DIGITS + 1);
  localparam int TW    = $clog2(ALU_TIMEOUT + 1);
  localparam int KEY_W = 20;

  localparam logic [CW-1:0]    CNT_FULL = CW'(MAX_DIGITS);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [TW-1:0]    TMR_LAST = TW'(ALU_TIMEOUT - 1);
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [KEY_W-1:0] KEY_ONE  = KEY_W'(1);
  // swd[3:1] are not keys at all: they never generate an event and never
  // make a real key press look like a multi-key chord.
  localparam logic [KEY_W-1:0] LIVE_MASK = 20'hFFFF1;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_RES = 2'd2;
  localparam logic [1:0] SEL_ERR = 2'd3;

  typedef enum logic [2:0] {
    ST_ENTRY_A,
    ST_ENTRY_B,
    ST_EXEC,
    ST_RESULT,
    ST_ERROR
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] key_prev;
  logic [CW-1:0]    cnt_a;
  logic [CW-1:0]    cnt_b;
  logic [TW-1:0]    timer;

  // -------------------------------------------------------------------------
  // Key event detection. Combined vector: [19:8]=swp, [7:0]=swd.
  // -------------------------------------------------------------------------
  logic [KEY_W-1:0] keys;
  logic [KEY_W-1:0] rise;
  logic             ev_valid;
  logic [4:0]       rise_idx;

  assign keys = {swp, swd};
  assign rise = keys & ~key_prev & LIVE_MASK;

  // Exactly one rising bit: non-zero and a power of two. Chords are dropped.
  assign ev_valid = (rise != '0) && ((rise & (rise - KEY_ONE)) == '0);

  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (rise[i]) begin
        rise_idx = 5'(i);
      end
    end
  end

  // Decoded event, acted upon by the FSM at the same clock edge, so its
  // effect is visible in the cycle after the rising level was seen.
  logic       key_digit;
  logic [3:0] key_val;
  logic       key_op;
  logic [1:0] op_val;
  logic       key_eq;
  logic       key_clear;
  logic       key_back;

  always_comb begin
    key_digit = 1'b0;
    key_val   = 4'd0;
    key_op    = 1'b0;
    op_val    = 2'd0;
    key_eq    = 1'b0;
    key_clear = 1'b0;
    key_back  = 1'b0;
    if (ev_valid) begin
      if (rise_idx == 5'd0) begin
        key_eq = 1'b1;
      end else if (rise_idx >= 5'd4 && rise_idx <= 5'd7) begin
        // swd[7..4] map to opcodes 0..3
        key_op = 1'b1;
        op_val = 2'(5'd7 - rise_idx);
      end else if (rise_idx == 5'd8) begin
        key_back = 1'b1;
      end else if (rise_idx == 5'd9) begin
        key_digit = 1'b1;
        key_val   = 4'd0;
      end else if (rise_idx == 5'd10) begin
        key_clear = 1'b1;
      end else if (rise_idx >= 5'd11) begin
        // swp[3..11] sit at combined index 11..19 -> digits 1..9
        key_digit = 1'b1;
        key_val   = 4'(rise_idx - 5'd10);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Digit acceptance: operand not full, and no leading zero on an empty one.
  // -------------------------------------------------------------------------
  logic           digit_ok_a;
  logic           digit_ok_b;
  logic [OPW-1:0] a_push;
  logic [OPW-1:0] b_push;
  logic [OPW-1:0] digit_ext;

  assign digit_ext  = OPW'(key_val);
  assign digit_ok_a = key_digit && (cnt_a != CNT_FULL) &&
                      !((key_val == 4'd0) && (cnt_a == '0));
  assign digit_ok_b = key_digit && (cnt_b != CNT_FULL) &&
                      !((key_val == 4'd0) && (cnt_b == '0));
  assign a_push     = (op_a << 4) | digit_ext;
  assign b_push     = (op_b << 4) | digit_ext;

  // -------------------------------------------------------------------------
  // Main sequencer. All outputs are registered here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ENTRY_A;
      key_prev  <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= 2'd0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      timer     <= '0;
      alu_start <= 1'b0;
      disp_sel  <= SEL_A;
      // Held high through reset so the LCD gets one initial redraw in the
      // first cycle after reset is released.
      disp_upd  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      key_prev  <= keys;
      alu_start <= 1'b0;
      disp_upd  <= 1'b0;

      if (key_clear && state != ST_EXEC) begin
        // '*' is a global escape except while the ALU owns the operands.
        state    <= ST_ENTRY_A;
        op_a     <= '0;
        op_b     <= '0;
        op_code  <= 2'd0;
        cnt_a    <= '0;
        cnt_b    <= '0;
        timer    <= '0;
        disp_sel <= SEL_A;
        disp_upd <= 1'b1;
      end else begin
        case (state)
          ST_ENTRY_A: begin
            if (digit_ok_a) begin
              op_a     <= a_push;
              cnt_a    <= cnt_a + CNT_ONE;
              disp_upd <= 1'b1;
            end else if (key_back && cnt_a != '0) begin
              op_a     <= op_a >> 4;
              cnt_a    <= cnt_a - CNT_ONE;
              disp_upd <= 1'b1;
            end else if (key_op) begin
              op_code  <= op_val;
              state    <= ST_ENTRY_B;
              disp_sel <= SEL_B;
              disp_upd <= 1'b1;
            end
          end

          ST_ENTRY_B: begin
            if (digit_ok_b) begin
              op_b     <= b_push;
              cnt_b    <= cnt_b + CNT_ONE;
              disp_upd <= 1'b1;
            end else if (key_back && cnt_b != '0) begin
              op_b     <= op_b >> 4;
              cnt_b    <= cnt_b - CNT_ONE;
              disp_upd <= 1'b1;
            end else if (key_op && cnt_b == '0) begin
              // Operator can still be changed until B has a digit; the
              // display content does not change, so no redraw.
              op_code <= op_val;
            end else if (key_eq) begin
              state     <= ST_EXEC;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              timer     <= '0;
            end
          end

          ST_EXEC: begin
            // alu_done wins over a timeout landing in the same cycle.
            if (alu_done) begin
              busy     <= 1'b0;
              timer    <= '0;
              disp_upd <= 1'b1;
              if (alu_err) begin
                state    <= ST_ERROR;
                disp_sel <= SEL_ERR;
              end else begin
                state    <= ST_RESULT;
                disp_sel <= SEL_RES;
              end
            end else if (timer == TMR_LAST) begin
              // ALU_TIMEOUT cycles spent in EXEC with no answer.
              busy     <= 1'b0;
              timer    <= '0;
              state    <= ST_ERROR;
              disp_sel <= SEL_ERR;
              disp_upd <= 1'b1;
            end else begin
              timer <= timer + TMR_ONE;
            end
          end

          ST_RESULT: begin
            // A digit starts a fresh calculation with that digit in A.
            if (key_digit) begin
              op_a     <= digit_ext;
              cnt_a    <= (key_val != 4'd0) ? CNT_ONE : '0;
              op_b     <= '0;
              cnt_b    <= '0;
              state    <= ST_ENTRY_A;
              disp_sel <= SEL_A;
              disp_upd <= 1'b1;
            end
          end

          ST_ERROR: begin
            // Only '*' (handled above) leaves this state.
          end

          default: begin
            state    <= ST_ENTRY_A;
            busy     <= 1'b0;
            disp_sel <= SEL_A;
            disp_upd <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;

  localparam int MAX_DIGITS  = 4;
  localparam int ALU_TIMEOUT = 1024;

  localparam logic [11:0] K_NONE = 12'h000;
  localparam logic [11:0] K_STAR = 12'h004;
  localparam logic [11:0] K_HASH = 12'h001;
  localparam logic [7:0]  D_NONE = 8'h00;
  localparam logic [7:0]  D_ADD  = 8'h80;
  localparam logic [7:0]  D_SUB  = 8'h40;
  localparam logic [7:0]  D_MUL  = 8'h20;
  localparam logic [7:0]  D_DIV  = 8'h10;
  localparam logic [7:0]  D_EQ   = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] swp = '0;
  logic [7:0]  swd = '0;
  logic        alu_done = 1'b0;
  logic        alu_err = 1'b0;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  op_code;
  logic        alu_start;
  logic [1:0]  disp_sel;
  logic        disp_upd;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_cyc = 0;

  calc_entry_ctrl #(
    .MAX_DIGITS (MAX_DIGITS),
    .ALU_TIMEOUT(ALU_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .swp      (swp),
    .swd      (swd),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_code  (op_code),
    .alu_start(alu_start),
    .alu_done (alu_done),
    .alu_err  (alu_err),
    .disp_sel (disp_sel),
    .disp_upd (disp_upd),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [1:0]  sel;
    logic        busy;
    logic        upd;
    logic        start;
  } snap_t;

  snap_t exp_q[$];

  function automatic snap_t mk(input logic [15:0] a, input logic [15:0] b,
                               input logic [1:0] op, input logic [1:0] sel,
                               input logic bsy, input logic upd, input logic st);
    snap_t s;
    s.a = a; s.b = b; s.op = op; s.sel = sel;
    s.busy = bsy; s.upd = upd; s.start = st;
    return s;
  endfunction

  function automatic logic [11:0] dg(input int k);
    logic [11:0] v;
    if (k == 0) v = 12'h002;
    else        v = 12'h001 << (k + 2);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of stimulus starting at a negedge, samples the DUT after
  // the following posedge, then releases and idles one more cycle.
  task automatic drive(input logic [11:0] p, input logic [7:0] d,
                       input logic dn, input logic er, output snap_t s);
    swp = p; swd = d; alu_done = dn; alu_err = er;
    @(negedge clk);
    s.a = op_a; s.b = op_b; s.op = op_code; s.sel = disp_sel;
    s.busy = busy; s.upd = disp_upd; s.start = alu_start;
    last_cyc = cyc;
    swp = '0; swd = '0; alu_done = 1'b0; alu_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic [11:0] p, input logic [7:0] d,
                      input logic dn, input logic er, input snap_t e_in);
    snap_t e;
    snap_t o;
    exp_q.push_back(e_in);
    drive(p, d, dn, er, o);
    e = exp_q.pop_front();
    $display("step %-12s a=%h b=%h op=%0d sel=%0d busy=%0b upd=%0b start=%0b",
             tag, o.a, o.b, o.op, o.sel, o.busy, o.upd, o.start);
    chk({tag, ".a"},     32'(o.a),     32'(e.a));
    chk({tag, ".b"},     32'(o.b),     32'(e.b));
    chk({tag, ".op"},    32'(o.op),    32'(e.op));
    chk({tag, ".sel"},   32'(o.sel),   32'(e.sel));
    chk({tag, ".busy"},  32'(o.busy),  32'(e.busy));
    chk({tag, ".upd"},   32'(o.upd),   32'(e.upd));
    chk({tag, ".start"}, 32'(o.start), 32'(e.start));
  endtask

  initial begin
    int t0;
    int elapsed;
    int upd_cnt;
    logic seen;
    logic upd_at;
    logic [1:0] sel_at;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.a",     32'(op_a),      32'h0);
    chk("rst.b",     32'(op_b),      32'h0);
    chk("rst.op",    32'(op_code),   32'h0);
    chk("rst.sel",   32'(disp_sel),  32'h0);
    chk("rst.busy",  32'(busy),      32'h0);
    chk("rst.start", 32'(alu_start), 32'h0);
    chk("rst.upd1",  32'(disp_upd),  32'h1);
    @(negedge clk);
    chk("rst.upd0",  32'(disp_upd),  32'h0);

    // ---------------- 1: 23 + 456 = ----------------
    step("t1.k2",  dg(2),  D_NONE, 0, 0, mk(16'h0023 >> 4, 16'h0, 0, 0, 0, 1, 0));
    step("t1.k3",  dg(3),  D_NONE, 0, 0, mk(16'h0023, 16'h0,    0, 0, 0, 1, 0));
    step("t1.add", K_NONE, D_ADD,  0, 0, mk(16'h0023, 16'h0,    0, 1, 0, 1, 0));
    step("t1.k4",  dg(4),  D_NONE, 0, 0, mk(16'h0023, 16'h0004, 0, 1, 0, 1, 0));
    step("t1.k5",  dg(5),  D_NONE, 0, 0, mk(16'h0023, 16'h0045, 0, 1, 0, 1, 0));
    step("t1.k6",  dg(6),  D_NONE, 0, 0, mk(16'h0023, 16'h0456, 0, 1, 0, 1, 0));
    step("t1.eq",  K_NONE, D_EQ,   0, 0, mk(16'h0023, 16'h0456, 0, 1, 1, 0, 1));
    chk("t1.start_single", 32'(alu_start), 32'h0);
    chk("t1.busy_held",    32'(busy),      32'h1);

    // ---------------- 2: result, then new digit ----------------
    step("t2.done", K_NONE, D_NONE, 1, 0, mk(16'h0023, 16'h0456, 0, 2, 0, 1, 0));
    step("t2.k7",   dg(7),  D_NONE, 0, 0, mk(16'h0007, 16'h0,    0, 0, 0, 1, 0));

    // ---------------- 3: digit limit and backspace ----------------
    step("t3.clr", K_STAR, D_NONE, 0, 0, mk(16'h0,    16'h0, 0, 0, 0, 1, 0));
    step("t3.k0",  dg(0),  D_NONE, 0, 0, mk(16'h0,    16'h0, 0, 0, 0, 0, 0));
    step("t3.k1",  dg(1),  D_NONE, 0, 0, mk(16'h0001, 16'h0, 0, 0, 0, 1, 0));
    step("t3.k2",  dg(2),  D_NONE, 0, 0, mk(16'h0012, 16'h0, 0, 0, 0, 1, 0));
    step("t3.k3",  dg(3),  D_NONE, 0, 0, mk(16'h0123, 16'h0, 0, 0, 0, 1, 0));
    step("t3.k4",  dg(4),  D_NONE, 0, 0, mk(16'h1234, 16'h0, 0, 0, 0, 1, 0));
    step("t3.k5",  dg(5),  D_NONE, 0, 0, mk(16'h1234, 16'h0, 0, 0, 0, 0, 0));
    step("t3.bs1", K_HASH, D_NONE, 0, 0, mk(16'h0123, 16'h0, 0, 0, 0, 1, 0));
    step("t3.bs2", K_HASH, D_NONE, 0, 0, mk(16'h0012, 16'h0, 0, 0, 0, 1, 0));
    step("t3.bs3", K_HASH, D_NONE, 0, 0, mk(16'h0001, 16'h0, 0, 0, 0, 1, 0));
    step("t3.bs4", K_HASH, D_NONE, 0, 0, mk(16'h0,    16'h0, 0, 0, 0, 1, 0));
    step("t3.bs5", K_HASH, D_NONE, 0, 0, mk(16'h0,    16'h0, 0, 0, 0, 0, 0));

    // ---------------- 4: chord ignored, held key = one event ----------------
    step("t4.chord", dg(8) | dg(7), D_NONE, 0, 0, mk(16'h0, 16'h0, 0, 0, 0, 0, 0));
    upd_cnt = 0;
    swp = dg(3);
    repeat (100) begin
      @(negedge clk);
      if (disp_upd) upd_cnt++;
    end
    swp = '0;
    @(negedge clk);
    $display("step t4.hold     a=%h upd_count=%0d", op_a, upd_cnt);
    chk("t4.hold.upd_count", 32'(upd_cnt), 32'd1);
    chk("t4.hold.a",         32'(op_a),    32'h0003);

    // ---------------- 5: ALU error path ----------------
    step("t5.clr",  K_STAR, D_NONE, 0, 0, mk(16'h0,    16'h0, 0, 0, 0, 1, 0));
    step("t5.k9",   dg(9),  D_NONE, 0, 0, mk(16'h0009, 16'h0, 0, 0, 0, 1, 0));
    step("t5.div",  K_NONE, D_DIV,  0, 0, mk(16'h0009, 16'h0, 3, 1, 0, 1, 0));
    step("t5.k0",   dg(0),  D_NONE, 0, 0, mk(16'h0009, 16'h0, 3, 1, 0, 0, 0));
    step("t5.eq",   K_NONE, D_EQ,   0, 0, mk(16'h0009, 16'h0, 3, 1, 1, 0, 1));
    step("t5.err",  K_NONE, D_NONE, 1, 1, mk(16'h0009, 16'h0, 3, 3, 0, 1, 0));
    step("t5.k5",   dg(5),  D_NONE, 0, 0, mk(16'h0009, 16'h0, 3, 3, 0, 0, 0));
    step("t5.clr2", K_STAR, D_NONE, 0, 0, mk(16'h0,    16'h0, 0, 0, 0, 1, 0));

    // ---------------- 6: operator rules, timeout, reset mid-EXEC ----------------
    step("t6.eqA",  K_NONE, D_EQ,   0, 0, mk(16'h0,    16'h0,    0, 0, 0, 0, 0));
    step("t6.k1",   dg(1),  D_NONE, 0, 0, mk(16'h0001, 16'h0,    0, 0, 0, 1, 0));
    step("t6.add",  K_NONE, D_ADD,  0, 0, mk(16'h0001, 16'h0,    0, 1, 0, 1, 0));
    step("t6.sub",  K_NONE, D_SUB,  0, 0, mk(16'h0001, 16'h0,    1, 1, 0, 0, 0));
    step("t6.k2",   dg(2),  D_NONE, 0, 0, mk(16'h0001, 16'h0002, 1, 1, 0, 1, 0));
    step("t6.mul",  K_NONE, D_MUL,  0, 0, mk(16'h0001, 16'h0002, 1, 1, 0, 0, 0));
    step("t6.eq",   K_NONE, D_EQ,   0, 0, mk(16'h0001, 16'h0002, 1, 1, 1, 0, 1));
    t0 = last_cyc;
    step("t6.star", K_STAR, D_NONE, 0, 0, mk(16'h0001, 16'h0002, 1, 1, 1, 0, 0));
    seen = 1'b0; elapsed = 0; upd_at = 1'b0; sel_at = 2'd0;
    for (int i = 0; i < ALU_TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        elapsed = cyc - t0;
        upd_at = disp_upd;
        sel_at = disp_sel;
        break;
      end
    end
    $display("step t6.timeout  seen=%0b elapsed=%0d sel=%0d", seen, elapsed, sel_at);
    chk("t6.tmo.seen",    32'(seen),    32'h1);
    chk("t6.tmo.elapsed", 32'(elapsed), 32'(ALU_TIMEOUT));
    chk("t6.tmo.sel",     32'(sel_at),  32'h3);
    chk("t6.tmo.upd",     32'(upd_at),  32'h1);
    chk("t6.tmo.a",       32'(op_a),    32'h0001);

    step("t6.clr",  K_STAR, D_NONE, 0, 0, mk(16'h0,    16'h0,    0, 0, 0, 1, 0));
    step("t6.k1b",  dg(1),  D_NONE, 0, 0, mk(16'h0001, 16'h0,    0, 0, 0, 1, 0));
    step("t6.addb", K_NONE, D_ADD,  0, 0, mk(16'h0001, 16'h0,    0, 1, 0, 1, 0));
    step("t6.k2b",  dg(2),  D_NONE, 0, 0, mk(16'h0001, 16'h0002, 0, 1, 0, 1, 0));
    step("t6.eqb",  K_NONE, D_EQ,   0, 0, mk(16'h0001, 16'h0002, 0, 1, 1, 0, 1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("step t6.rst      a=%h b=%h busy=%0b upd=%0b", op_a, op_b, busy, disp_upd);
    chk("t6.rst.a",    32'(op_a),     32'h0);
    chk("t6.rst.b",    32'(op_b),     32'h0);
    chk("t6.rst.op",   32'(op_code),  32'h0);
    chk("t6.rst.sel",  32'(disp_sel), 32'h0);
    chk("t6.rst.busy", 32'(busy),     32'h0);
    chk("t6.rst.upd",  32'(disp_upd), 32'h1);
    @(negedge clk);
    step("t6.late", K_NONE, D_NONE, 1, 0, mk(16'h0,    16'h0, 0, 0, 0, 0, 0));
    step("t6.k5",   dg(5),  D_NONE, 0, 0, mk(16'h0005, 16'h0, 0, 0, 0, 1, 0));

    // ---------------- alu_done in the same cycle as alu_start ----------------
    step("t7.add", K_NONE, D_ADD, 0, 0, mk(16'h0005, 16'h0, 0, 1, 0, 1, 0));
    swd = D_EQ;
    @(negedge clk);
    chk("t7.start", 32'(alu_start), 32'h1);
    chk("t7.busy",  32'(busy),      32'h1);
    swd = '0; alu_done = 1'b1; alu_err = 1'b0;
    @(negedge clk);
    alu_done = 1'b0;
    $display("step t7.fastdone sel=%0d busy=%0b upd=%0b", disp_sel, busy, disp_upd);
    chk("t7.sel",   32'(disp_sel),  32'h2);
    chk("t7.busyd", 32'(busy),      32'h0);
    chk("t7.upd",   32'(disp_upd),  32'h1);
    @(negedge clk);
    chk("t7.nostart", 32'(alu_start), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
